// File: rtl/note_layout_if.sv
// Note-event handshake, renderer draw bundle and clear-sweep pixel port of the
// note layout sequencer, grouped for the source (master) and sequencer (slave).
interface note_layout_if;
  logic [3:0] note_in;
  logic [1:0] octave_in;
  logic       note_valid;
  logic       ready;
  logic       clear_req;
  logic [3:0] note;
  logic [1:0] octave;
  logic [7:0] x;
  logic [6:0] y;
  logic       ld_note;
  logic       clear;
  logic [7:0] clr_x;
  logic [6:0] clr_y;
  logic       clr_we;

  modport master (
    output note_in, octave_in, note_valid, clear_req,
    input  ready, note, octave, x, y, ld_note, clear, clr_x, clr_y, clr_we
  );

  modport slave (
    input  note_in, octave_in, note_valid, clear_req,
    output ready, note, octave, x, y, ld_note, clear, clr_x, clr_y, clr_we
  );
endinterface

// File: rtl/note_layout_ctrl.sv
// Note layout sequencer: places accepted notes into a COLS x ROWS cell grid,
// strobes the glyph renderer per note and sweeps the screen black when asked.
module note_layout_ctrl #(
  parameter int DRAW_CYCLES = 432,
  parameter int CELL_W      = 40,
  parameter int CELL_H      = 16,
  parameter int COLS        = 4,
  parameter int ROWS        = 7,
  parameter int SCR_W       = 160,
  parameter int SCR_H       = 120
) (
  input  logic          clk,
  input  logic          resetn,
  note_layout_if.slave  bus
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CNT_W = $clog2(DRAW_CYCLES + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAW_CYCLES - 1);
  localparam logic [7:0]       SX_LAST  = 8'(SCR_W - 1);
  localparam logic [6:0]       SY_LAST  = 7'(SCR_H - 1);
  localparam logic [7:0]       CELL_W_L = 8'(CELL_W);
  localparam logic [6:0]       CELL_H_L = 7'(CELL_H);

  typedef enum logic [1:0] {
    SWEEP = 2'd0,
    IDLE  = 2'd1,
    DRAW  = 2'd2,
    SKIP  = 2'd3
  } state_t;

  function automatic logic note_in_range(input logic [3:0] code);
    return (code >= 4'd1) && (code <= 4'd12);
  endfunction

  state_t           state_r, state_s;
  logic [COL_W-1:0] col_r, col_s;
  logic [ROW_W-1:0] row_r, row_s;
  logic             full_r, full_s;
  logic             pend_clr_r, pend_clr_s;
  logic             pend_draw_r, pend_draw_s;
  logic [CNT_W-1:0] draw_cnt_r, draw_cnt_s;
  logic [7:0]       sx_r, sx_s;
  logic [6:0]       sy_r, sy_s;
  logic             ready_r, ready_s;
  logic             ld_note_r, ld_note_s;
  logic             clear_r, clear_s;
  logic             clr_we_r, clr_we_s;
  logic [7:0]       clr_x_r, clr_x_s;
  logic [6:0]       clr_y_r, clr_y_s;
  logic [7:0]       x_r, x_s;
  logic [6:0]       y_r, y_s;
  logic [3:0]       note_r, note_s;
  logic [1:0]       octave_r, octave_s;
  logic             accept_s;
  logic             sweep_last_s;

  assign accept_s     = bus.note_valid & ready_r & ~bus.clear_req;
  // The sweep is over once the bottom-right pixel has been presented.
  assign sweep_last_s = clr_we_r && (clr_x_r == SX_LAST) && (clr_y_r == SY_LAST);

  // Next-state, cursor and registered-output computation.
  always_comb begin
    state_s     = state_r;
    col_s       = col_r;
    row_s       = row_r;
    full_s      = full_r;
    pend_clr_s  = pend_clr_r;
    pend_draw_s = pend_draw_r;
    draw_cnt_s  = {CNT_W{1'b0}};
    sx_s        = sx_r;
    sy_s        = sy_r;
    clr_x_s     = clr_x_r;
    clr_y_s     = clr_y_r;
    x_s         = x_r;
    y_s         = y_r;
    note_s      = note_r;
    octave_s    = octave_r;
    ready_s     = 1'b0;
    ld_note_s   = 1'b0;
    clear_s     = 1'b1;
    clr_we_s    = 1'b0;

    case (state_r)
      SWEEP: begin
        pend_clr_s = 1'b0;
        if (sweep_last_s) begin
          col_s  = {COL_W{1'b0}};
          row_s  = {ROW_W{1'b0}};
          full_s = 1'b0;
          if (pend_draw_r) begin
            state_s     = DRAW;
            pend_draw_s = 1'b0;
            x_s         = 8'd0;
            y_s         = 7'd0;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = SWEEP;
        end
      end
      IDLE: begin
        if (bus.clear_req) begin
          state_s = SWEEP;
        end else if (accept_s) begin
          if (note_in_range(bus.note_in)) begin
            note_s   = bus.note_in;
            octave_s = bus.octave_in;
            // An overflowing note is held while the screen is wiped, then drawn at (0,0).
            if (full_r) begin
              state_s     = SWEEP;
              pend_draw_s = 1'b1;
            end else begin
              state_s = DRAW;
              x_s     = 8'(col_r) * CELL_W_L;
              y_s     = 7'(row_r) * CELL_H_L;
            end
          end else begin
            state_s = SKIP;
          end
        end else begin
          state_s = IDLE;
        end
      end
      DRAW: begin
        if (draw_cnt_r == CNT_LAST) begin
          if (col_r == COL_LAST) begin
            col_s = {COL_W{1'b0}};
            if (row_r == ROW_LAST) begin
              row_s  = {ROW_W{1'b0}};
              full_s = 1'b1;
            end else begin
              row_s = row_r + 1'b1;
            end
          end else begin
            col_s = col_r + 1'b1;
          end
          state_s    = (pend_clr_r | bus.clear_req) ? SWEEP : IDLE;
          pend_clr_s = 1'b0;
        end else begin
          draw_cnt_s = draw_cnt_r + 1'b1;
          pend_clr_s = pend_clr_r | bus.clear_req;
        end
      end
      SKIP: begin
        state_s    = (pend_clr_r | bus.clear_req) ? SWEEP : IDLE;
        pend_clr_s = 1'b0;
      end
      default: begin
        state_s = SWEEP;
      end
    endcase

    ready_s   = (state_s == IDLE);
    ld_note_s = (state_s == DRAW);

    // Sweep counters point at the next pixel and rest at (0,0) outside a sweep.
    if (state_s == SWEEP) begin
      clear_s  = 1'b0;
      clr_we_s = 1'b1;
      clr_x_s  = sx_r;
      clr_y_s  = sy_r;
      if (sx_r == SX_LAST) begin
        sx_s = 8'd0;
        if (sy_r == SY_LAST) begin
          sy_s = 7'd0;
        end else begin
          sy_s = sy_r + 7'd1;
        end
      end else begin
        sx_s = sx_r + 8'd1;
      end
    end else begin
      clear_s  = 1'b1;
      clr_we_s = 1'b0;
      sx_s     = 8'd0;
      sy_s     = 7'd0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= SWEEP;
    end else begin
      state_r <= state_s;
    end
  end

  // Cursor, counters, pending flags and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_r       <= {COL_W{1'b0}};
      row_r       <= {ROW_W{1'b0}};
      full_r      <= 1'b0;
      pend_clr_r  <= 1'b0;
      pend_draw_r <= 1'b0;
      draw_cnt_r  <= {CNT_W{1'b0}};
      sx_r        <= 8'd0;
      sy_r        <= 7'd0;
      ready_r     <= 1'b0;
      ld_note_r   <= 1'b0;
      clear_r     <= 1'b1;
      clr_we_r    <= 1'b0;
      clr_x_r     <= 8'd0;
      clr_y_r     <= 7'd0;
      x_r         <= 8'd0;
      y_r         <= 7'd0;
      note_r      <= 4'd0;
      octave_r    <= 2'd0;
    end else begin
      col_r       <= col_s;
      row_r       <= row_s;
      full_r      <= full_s;
      pend_clr_r  <= pend_clr_s;
      pend_draw_r <= pend_draw_s;
      draw_cnt_r  <= draw_cnt_s;
      sx_r        <= sx_s;
      sy_r        <= sy_s;
      ready_r     <= ready_s;
      ld_note_r   <= ld_note_s;
      clear_r     <= clear_s;
      clr_we_r    <= clr_we_s;
      clr_x_r     <= clr_x_s;
      clr_y_r     <= clr_y_s;
      x_r         <= x_s;
      y_r         <= y_s;
      note_r      <= note_s;
      octave_r    <= octave_s;
    end
  end

  assign bus.ready   = ready_r;
  assign bus.ld_note = ld_note_r;
  assign bus.clear   = clear_r;
  assign bus.clr_we  = clr_we_r;
  assign bus.clr_x   = clr_x_r;
  assign bus.clr_y   = clr_y_r;
  assign bus.x       = x_r;
  assign bus.y       = y_r;
  assign bus.note    = note_r;
  assign bus.octave  = octave_r;

endmodule
